beep_melody: RTL and testbench

- Drives a passive buzzer with a repeating 7-note scale: DO, RE, MI, FA, SO, LA, XI, then back to DO.
- Each note lasts CNT_MAX+1 clocks.
- During a note, the output is a square wave whose period (in clocks) is the note parameter, at 50% duty.
- Leaf block that sits directly between the board clock/reset and the buzzer pin.

---
 rtl/beep_pkg.sv | 19 +
 rtl/beep_tone_gen.sv | 61 ++++++
 rtl/beep_melody.sv | 96 +++++++++
 tb/tb_beep_melody.sv | 131 +++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared widths, note index type and the note-sequencing helper for beep_melody.
package beep_pkg;

  localparam int NOTE_NUM = 7;
  localparam int CNT_W    = 25;
  localparam int FREQ_W   = 18;

  typedef logic [2:0] note_idx_t;

  // Step through the scale 0..NOTE_NUM-1; anything at or past the last note wraps to DO.
  function automatic note_idx_t next_note(input note_idx_t idx);
    if (idx >= 3'(NOTE_NUM - 1)) begin
      return 3'd0;
    end else begin
      return idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone generator: period counter, half-period compare and registered buzzer drive.
// Optional BEEP_GATE_EN adds gate_i, which freezes the counter and silences the output.
module beep_tone_gen
  import beep_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef BEEP_GATE_EN
  input  logic              gate_i,
`endif
  input  logic [FREQ_W-1:0] freq_data_i,
  input  logic              restart_i,
  output logic              beep_o
);

  localparam logic [FREQ_W-1:0] FREQ_ONE  = FREQ_W'(1'b1);
  localparam logic [FREQ_W-1:0] FREQ_ZERO = {FREQ_W{1'b0}};

  logic [FREQ_W-1:0] freq_cnt_q;
  logic [FREQ_W-1:0] freq_cnt_d;
  logic [FREQ_W-1:0] duty_s;
  logic              beep_d;
  logic              run_s;

`ifdef BEEP_GATE_EN
  assign run_s = gate_i;
`else
  assign run_s = 1'b1;
`endif

  // Next-state for the period counter and the buzzer level it implies.
  always_comb begin
    duty_s     = freq_data_i >> 1;
    freq_cnt_d = freq_cnt_q;
    beep_d     = 1'b0;
    if (run_s) begin
      // A note change also restarts the period so every note begins phase-aligned.
      if (restart_i || (freq_cnt_q == (freq_data_i - FREQ_ONE))) begin
        freq_cnt_d = FREQ_ZERO;
      end else begin
        freq_cnt_d = freq_cnt_q + FREQ_ONE;
      end
      beep_d = (freq_cnt_q >= duty_s);
    end else begin
      freq_cnt_d = freq_cnt_q;
      beep_d     = 1'b0;
    end
  end

  // Period counter and buzzer output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      freq_cnt_q <= FREQ_ZERO;
      beep_o     <= 1'b0;
    end else begin
      freq_cnt_q <= freq_cnt_d;
      beep_o     <= beep_d;
    end
  end

endmodule

// File: rtl/beep_melody.sv
// Passive-buzzer driver cycling DO..XI, each note CNT_MAX+1 clocks long.
// Optional BEEP_GATE_EN adds beep_en to pause the melody and mute the buzzer.
module beep_melody
  import beep_pkg::*;
#(
  parameter logic [CNT_W-1:0]  CNT_MAX = 25'd24_999_999,
  parameter logic [FREQ_W-1:0] DO      = 18'd190_839,
  parameter logic [FREQ_W-1:0] RE      = 18'd170_067,
  parameter logic [FREQ_W-1:0] MI      = 18'd151_514,
  parameter logic [FREQ_W-1:0] FA      = 18'd143_265,
  parameter logic [FREQ_W-1:0] SO      = 18'd127_550,
  parameter logic [FREQ_W-1:0] LA      = 18'd113_635,
  parameter logic [FREQ_W-1:0] XI      = 18'd101_214
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
`ifdef BEEP_GATE_EN
  input  logic beep_en,
`endif
  output logic beep
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  note_idx_t         note_idx_q;
  note_idx_t         note_idx_d;
  logic [FREQ_W-1:0] freq_data_s;
  logic              restart_s;
  logic              run_s;

`ifdef BEEP_GATE_EN
  assign run_s = beep_en;
`else
  assign run_s = 1'b1;
`endif

  assign restart_s = (cnt_q == CNT_MAX);

  // Tone period for the current note; the unreachable index 7 falls back to DO.
  always_comb begin
    case (note_idx_q)
      3'd0:    freq_data_s = DO;
      3'd1:    freq_data_s = RE;
      3'd2:    freq_data_s = MI;
      3'd3:    freq_data_s = FA;
      3'd4:    freq_data_s = SO;
      3'd5:    freq_data_s = LA;
      3'd6:    freq_data_s = XI;
      default: freq_data_s = DO;
    endcase
  end

  // Note-duration counter and note index advance.
  always_comb begin
    cnt_d      = cnt_q;
    note_idx_d = note_idx_q;
    if (run_s) begin
      if (restart_s) begin
        cnt_d      = CNT_ZERO;
        note_idx_d = next_note(note_idx_q);
      end else begin
        cnt_d      = cnt_q + CNT_ONE;
        note_idx_d = note_idx_q;
      end
    end else begin
      cnt_d      = cnt_q;
      note_idx_d = note_idx_q;
    end
  end

  // Duration and note state registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cnt_q      <= CNT_ZERO;
      note_idx_q <= 3'd0;
    end else begin
      cnt_q      <= cnt_d;
      note_idx_q <= note_idx_d;
    end
  end

  beep_tone_gen u_tone_gen (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst_n),
`ifdef BEEP_GATE_EN
    .gate_i      (beep_en),
`endif
    .freq_data_i (freq_data_s),
    .restart_i   (restart_s),
    .beep_o      (beep)
  );

endmodule

// File: tb/tb_beep_melody.sv
// Directed scoreboard bench for beep_melody with shortened notes (1000 clocks each).
module tb_beep_melody;

  localparam int N = 1000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic beep;
`ifdef BEEP_GATE_EN
  logic beep_en   = 1'b1;
`endif

  logic exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   e           = 0;

  always #5 sys_clk = ~sys_clk;

  beep_melody #(
    .CNT_MAX (25'd999),
    .DO      (18'd190),
    .RE      (18'd170),
    .MI      (18'd151),
    .FA      (18'd143),
    .SO      (18'd127),
    .LA      (18'd113),
    .XI      (18'd101)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
`ifdef BEEP_GATE_EN
    .beep_en   (beep_en),
`endif
    .beep      (beep)
  );

  function automatic int period(input int note);
    case (note)
      0:       return 190;
      1:       return 170;
      2:       return 151;
      3:       return 143;
      4:       return 127;
      5:       return 113;
      6:       return 101;
      default: return 190;
    endcase
  endfunction

  // Expected beep after the edge that follows k running clocks since reset.
  function automatic logic model(input int k);
    int cnt;
    int p;
    cnt = k % N;
    p   = period((k / N) % 7);
    return ((cnt % p) >= (p / 2)) ? 1'b1 : 1'b0;
  endfunction

  task automatic step(input logic rst, input logic en, input string tag, output logic obs);
    logic exp_v;
    sys_rst_n = rst;
`ifdef BEEP_GATE_EN
    beep_en = en;
`endif
    if (rst) begin
      exp_q.push_back(1'b0);
      e = 0;
    end else if (!en) begin
      exp_q.push_back(1'b0);
    end else begin
      exp_q.push_back(model(e));
      e = e + 1;
    end
    @(posedge sys_clk);
    #1;
    exp_v = exp_q.pop_front();
    obs   = beep;
    vectors = vectors + 1;
    assert (beep === exp_v) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s k=%0d beep=%b expected %b", tag, e, beep, exp_v);
    end
  endtask

  task automatic run(input int n, input logic en, input string tag);
    logic o;
    for (int i = 0; i < n; i++) step(1'b0, en, tag, o);
  endtask

  task automatic count_high(input int n, input string tag, input int exp_hi);
    logic o;
    int   hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, tag, o);
      if (o === 1'b1) hi = hi + 1;
    end
    vectors = vectors + 1;
    assert (hi == exp_hi) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s_high_count got=%0d expected %0d", tag, hi, exp_hi);
    end
  endtask

  initial begin
    logic o;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "reset", o);
    count_high(190, "do_period", 95);
    run(810, 1'b1, "do_tail");
    count_high(170, "re_period", 85);
    run(830, 1'b1, "re_tail");
    count_high(151, "mi_period", 76);
    run(3849, 1'b1, "mid_scale");
    count_high(1000, "xi_note", 500);
    count_high(190, "do_wrap", 95);
    run(3310, 1'b1, "to_fa");
    step(1'b1, 1'b1, "mid_fa_reset", o);
    count_high(190, "do_restart", 95);
    count_high(810, "do_truncated", 380);
`ifdef BEEP_GATE_EN
    run(300, 1'b1, "pre_gate");
    run(1000, 1'b0, "gated");
    run(1500, 1'b1, "post_gate");
`endif
    run(500, 1'b1, "final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
